// File: rtl/ascon_pack.sv
// ascon_pack: shared Ascon state type, FSM encoding, round-constant and S-box tables
package ascon_pack;
  localparam int ROUNDS_A = 12;
  localparam int ROUNDS_B = 6;
  typedef logic [4:0][63:0] type_state;
  typedef enum logic [1:0] {IDLE, RUN, DONE} type_fsm;
  localparam logic [7:0] RC [12] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };
  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
endpackage

// File: rtl/ascon_permutation_engine_ps.sv
// ascon_ps: Ascon substitution layer, one 5-bit S-box per bit column (x0 is the MSB)
module ascon_ps
  import ascon_pack::*;
(
  input  type_state state,
  output type_state sub
);
  for (genvar j = 0; j < 64; j++) begin : g_col
    logic [4:0] y;
    assign y = SBOX[{state[0][j], state[1][j], state[2][j], state[3][j], state[4][j]}];
    assign {sub[0][j], sub[1][j], sub[2][j], sub[3][j], sub[4][j]} = y;
  end
endmodule

// File: rtl/ascon_pl.sv
// ascon_pl: Ascon linear diffusion layer, one rotate-xor pair per state word
module ascon_pl
  import ascon_pack::*;
(
  input  type_state state,
  output type_state diff
);
  assign diff[0] = state[0] ^ ror(state[0], 19) ^ ror(state[0], 28);
  assign diff[1] = state[1] ^ ror(state[1], 61) ^ ror(state[1], 39);
  assign diff[2] = state[2] ^ ror(state[2], 1)  ^ ror(state[2], 6);
  assign diff[3] = state[3] ^ ror(state[3], 10) ^ ror(state[3], 17);
  assign diff[4] = state[4] ^ ror(state[4], 7)  ^ ror(state[4], 41);
endmodule

// File: rtl/ascon_permutation_engine.sv
// ascon_permutation_engine: iterative Ascon pa/pb permutation, one full round per clock
module ascon_permutation_engine
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam logic [3:0] LAST = 4'(ROUNDS_A - 1);
  type_fsm fsm, fsm_nx;
  type_state st, pc, ps, pl;
  logic [3:0] rnd;
  always_comb begin
    pc = st;
    pc[2][7:0] = st[2][7:0] ^ RC[rnd];
  end
  ascon_ps u_ps (.state(pc), .sub(ps));
  ascon_pl u_pl (.state(ps), .diff(pl));
  always_comb begin
    fsm_nx = fsm == IDLE ? (start_i ? RUN : IDLE) :
             fsm == RUN  ? (rnd == LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm <= IDLE;
      st  <= '0;
      rnd <= '0;
    end else begin
      fsm <= fsm_nx;
      if (fsm == IDLE && start_i) begin
        st  <= state_i;
        rnd <= mode_i ? 4'd0 : 4'(ROUNDS_A - ROUNDS_B);
      end else if (fsm == RUN) begin
        st  <= pl;
        rnd <= rnd == LAST ? LAST : rnd + 4'd1;
      end
    end
  end
  assign state_o = st;
  assign round_o = rnd;
  assign busy_o  = fsm == RUN;
  assign done_o  = fsm == DONE;
endmodule

// File: tb/tb_ascon_permutation_engine.sv
// tb_ascon_permutation_engine: randomized checks of the permutation engine against a bit-sliced reference model
module tb_ascon_permutation_engine;
  import ascon_pack::type_state;
  typedef logic [12:0][4:0][63:0] trace_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic mode = 1'b0;
  type_state st_in = '0;
  type_state state_o;
  logic [3:0] round_o;
  logic busy_o, done_o;
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  ascon_permutation_engine dut (
    .clock_i(clk), .resetb_i(rst_n), .start_i(start), .mode_i(mode),
    .state_i(st_in), .state_o(state_o), .round_o(round_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [7:0] m_rc(input int r);
    return 8'(((15 - r) << 4) | r);
  endfunction

  // Ascon reference S-box as the bit-sliced boolean network
  function automatic type_state m_sbox(input type_state s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    type_state o;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x0 ^= x4; x4 ^= x3; x2 ^= x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
    x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
    o[0] = x0; o[1] = x1; o[2] = x2; o[3] = x3; o[4] = x4;
    return o;
  endfunction

  function automatic type_state m_round(input type_state s, input int r);
    type_state t, o;
    t = s;
    t[2] = t[2] ^ {56'd0, m_rc(r)};
    t = m_sbox(t);
    o[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
    o[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
    o[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
    o[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
    o[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
    return o;
  endfunction

  function automatic trace_t mk_trace(input type_state s, input int first);
    trace_t t;
    t = '0;
    t[0] = s;
    for (int k = 1; k <= 12 - first; k++) t[k] = m_round(t[k-1], first + k - 1);
    return t;
  endfunction

  function automatic type_state rnd_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // model: trace of every intermediate state, cycle index since the accepting edge
  trace_t tr = '0;
  int n = 0, cyc = 0;
  bit active = 1'b0;
  type_state hs = '0;
  logic [3:0] hr = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      hs <= '0;
      hr <= '0;
    end else if (active) begin
      cyc <= cyc + 1;
      if (cyc == n) begin
        active <= 1'b0;
        hs <= tr[n];
        hr <= 4'd11;
      end
    end else if (start) begin
      tr <= mk_trace(st_in, mode ? 0 : 6);
      n <= mode ? 12 : 6;
      cyc <= 0;
      active <= 1'b1;
    end
  end

  always @(negedge clk) begin
    type_state es;
    logic [3:0] er;
    es = active ? tr[cyc] : hs;
    er = !active ? hr : (cyc < n ? 4'(12 - n + cyc) : 4'd11);
    chk("state_o", state_o, es);
    chk("round_o", 320'(round_o), 320'(er));
    chk("busy_o", 320'(busy_o), 320'(active && cyc < n));
    chk("done_o", 320'(done_o), 320'(active && cyc == n));
    if (done_o) done_cnt++;
  end

  // caller is at a negedge in IDLE; checks start->done latency and the single done pulse
  task automatic go(input bit md, input type_state s, input bit noise, input string nm);
    int k, d0;
    d0 = done_cnt;
    mode = md; st_in = s; start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start = 1'b0; mode = 1'($urandom); st_in = rnd_state();
      if (noise && busy_o && (round_o == 4'd3 || round_o == 4'd11)) start = 1'b1;
    end while (!done_o && k < 40);
    if (noise) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " latency"}, 320'(k), md ? 320'd13 : 320'd7);
    chk({nm, " done pulses"}, 320'(done_cnt - d0), 320'd1);
  endtask

  initial begin
    type_state z, v;
    int k, d0;
    logic [4:0] sb_ref [32];
    logic [7:0] rc_ref [6];
    sb_ref = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
               5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
               5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
               5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    rc_ref = '{8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
    for (int i = 0; i < 32; i++) begin
      type_state c, o;
      logic [4:0] iv;
      iv = 5'(i);
      c = '0;
      for (int w = 0; w < 5; w++) c[w][0] = iv[4-w];
      o = m_sbox(c);
      chk("model sbox", 320'({o[0][0], o[1][0], o[2][0], o[3][0], o[4][0]}), 320'(sb_ref[i]));
    end
    chk("model rc0", 320'(m_rc(0)), 320'h0f0);
    for (int r = 6; r < 12; r++) chk("model rc pb", 320'(m_rc(r)), 320'(rc_ref[r-6]));

    #1 rst_n = 1'b0;
    repeat (6) begin
      @(negedge clk);
      start = 1'($urandom); mode = 1'($urandom); st_in = rnd_state();
    end
    start = 1'b0;
    #2 rst_n = 1'b1;
    @(negedge clk);

    v = '0;
    v[0] = 64'h80400c0600000000;
    go(1'b1, v, 1'b0, "pa vector");
    z = '0;
    go(1'b0, z, 1'b0, "pb zero");
    go(1'b1, rnd_state(), 1'b1, "pa start ignored");
    go(1'b0, rnd_state(), 1'b1, "pb start ignored");

    d0 = done_cnt;
    mode = 1'b1; st_in = rnd_state(); start = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      start = 1'b0;
    end while (!(busy_o && round_o == 4'd5) && k < 40);
    chk("reach round 5", 320'(k), 320'd6);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("aborted done pulses", 320'(done_cnt - d0), 320'd0);
    go(1'b0, rnd_state(), 1'b0, "pb after reset");
    go(1'b1, rnd_state(), 1'b0, "back to back");

    for (int t = 0; t < 15; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      go(1'($urandom), rnd_state(), 1'($urandom), "random op");
    end
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ascon_permutation_engine.md
Name: ascon_permutation_engine

Overview:
- Iterative Ascon permutation core: holds the 320-bit state in a register and applies one full round per clock.
- Round order is constant addition, then substitution layer, then the existing linear diffusion layer. The diffusion output is written back into the state register.
- Runs pa (12 rounds) or pb (6 rounds) under a start/done handshake.
- Sits between the mode FSM (initialisation/associated-data/plaintext/finalisation sequencing) and the diffusion layer, which it instantiates and consumes.

Parameters:
- ROUNDS_A, 12, number of rounds for pa; fixed by the Ascon-128 standard.
- ROUNDS_B, 6, number of rounds for pb; fixed by the Ascon-128 standard.

Ports:
- clock_i  in  1  system clock; all state updates on the rising edge.
- resetb_i  in  1  asynchronous, active-low reset.
- start_i  in  1  request to start a permutation; sampled only in IDLE.
- mode_i  in  1  1 = pa (12 rounds), 0 = pb (6 rounds); sampled with start_i.
- state_i  in  type_state (5 x 64)  state loaded on an accepted start.
- state_o  out  type_state  current contents of the state register.
- round_o  out  4  current round index (0..11).
- busy_o  out  1  high while rounds are executing.
- done_o  out  1  one-cycle pulse; state_o holds the final permuted state.

Behaviour:
- Reset (resetb_i low, asynchronous): state register = all zero; round counter = 0; FSM = IDLE; busy_o = 0; done_o = 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE, start_i = 1 at edge E0:
    - state register <= state_i.
    - round counter <= 0 if mode_i = 1, else 12 - ROUNDS_B = 6.
    - next state = RUN.
  - IDLE, start_i = 0: hold everything.
  - RUN: each edge, state register <= Pl(Ps(Pc(state, rc))) and round counter increments.
    - When the counter equals 11 at the edge, that is the last round: next state = DONE and the counter holds 11.
  - DONE: lasts exactly one cycle, then returns to IDLE.
- Latency: pa final state is visible on state_o after edge E0+12; pb after edge E0+6. done_o is high during the following cycle.
- Round constant rc for round index r:
  - rc = {4'(15 - r), 4'(r)}, i.e. 0xF0, 0xE1, 0xD2, ... 0x4B.
  - It is XORed into bits [7:0] of word x2 only; bits [63:8] of x2 are unchanged.
- Substitution layer: Ascon 5-bit S-box applied to each of the 64 bit-slices. Bit j of x0..x4 forms one column, with x0 as the MSB.
- busy_o = (FSM == RUN). done_o = (FSM == DONE). Both are decoded from registered state, so neither has a combinational path from an input.
- round_o = the round counter. In IDLE and DONE it holds its last value.
- start_i in RUN or DONE is ignored: no restart, no queuing. The caller must re-assert start_i in IDLE.
- state_o holds the final state indefinitely after DONE, until the next accepted start.
- mode_i and state_i are don't-care except at the edge where start is accepted.
- Reset asserted mid-RUN: the permutation is aborted immediately and all outputs return to their reset values. No done_o pulse is generated.
- No combinational path from state_i to state_o. The whole round function is combinational between register stages: one round per cycle, no internal pipelining.

Decomposition:
- Package ascon_pack (existing) holds:
  - type_state (array of 5 x 64-bit words).
  - Round-constant table: 12 x 8-bit, indexed by round.
  - S-box table: 32 x 5-bit.
  - ROUNDS_A and ROUNDS_B constants.
- Sub-modules:
  - Pc: constant addition. Inputs: state, round index.
  - Ps: substitution layer. Combinational; 64 instances of a 5-bit S-box via a generate loop.
  - Existing linear diffusion layer, instantiated unchanged.
- Ps is the one natural new sub-module. Pc may be inlined if trivial.
- The engine top contains only the FSM, the round counter and the state register.

Test Plan:
- Reset check: drive resetb_i low with random inputs -> state_o = 0, round_o = 0, busy_o = 0, done_o = 0; start_i pulses are ignored while reset is held.
- pa vector: start_i = 1, mode_i = 1, state_i = {x0 = 0x80400c0600000000, x1..x4 = 0}:
  - busy_o high for exactly 12 cycles.
  - round_o steps 0..11.
  - done_o pulses once, 13 cycles after the start edge.
  - state_o matches the golden C model output for this input.
- pb constant sequence: mode_i = 0, all-zero state_i:
  - round_o steps 6..11; the rc applied each cycle is 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B (checked on the x2 low byte via the golden model).
  - done_o arrives 7 cycles after the start edge.
- Start ignored while busy: assert start_i with a different state_i at rounds 3 and 11, and during DONE -> the result is identical to the uninterrupted run; exactly one done_o pulse.
- Reset mid-operation: deassert resetb_i at round 5 of pa, release, then start a new pb -> no done_o for the aborted run; the pb result matches the golden model.
- Back-to-back operations: assert start_i in the first IDLE cycle after done_o, with a new state -> accepted; state_o holds the previous result until that accepting edge.
